// File: rtl/mem_arbiter.sv
// Two-port (I/D cache) arbiter onto a single system bus; ready returns WAIT_STATES+2 cycles after the request is sampled.
// Backpressure: requests are level strobes held until ready; strobes outside IDLE are ignored. Round-robin tie-break under `ARB_RR_EN, else D wins.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_strobe,
  input  logic              I_rw,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic              I_ready,
  output logic [DATA_W-1:0] I_rdata,
  input  logic              D_strobe,
  input  logic              D_rw,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_ready,
  output logic [DATA_W-1:0] D_rdata,
  output logic              S_strobe,
  output logic              S_rw,
  output logic [ADDR_W-1:0] S_addr,
  output logic [DATA_W-1:0] S_wdata,
  input  logic [DATA_W-1:0] S_rdata,
  output logic              grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       any_req;
  logic       pick_d;

`ifdef ARB_RR_EN
  logic last_grant;
  // On a tie, serve whichever port was not served last.
  assign pick_d = D_strobe && (!I_strobe || !last_grant);
`else
  assign pick_d = D_strobe;
`endif

  assign any_req  = I_strobe || D_strobe;
  assign S_strobe = (state == ISSUE);
  assign I_ready  = (state == DONE) && !grant;
  assign D_ready  = (state == DONE) &&  grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= 1'b0;
      S_rw     <= 1'b0;
      S_addr   <= '0;
      S_wdata  <= '0;
      wait_cnt <= 4'd0;
      I_rdata  <= '0;
      D_rdata  <= '0;
`ifdef ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant   <= pick_d;
          S_rw    <= pick_d ? D_rw    : I_rw;
          S_addr  <= pick_d ? D_addr  : I_addr;
          S_wdata <= pick_d ? D_wdata : I_wdata;
        end
        ISSUE: wait_cnt <= 4'(WAIT_STATES - 1);
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!S_rw) begin
            // Last wait cycle: the system bus read data is valid now.
            if (grant) D_rdata <= S_rdata;
            else       I_rdata <= S_rdata;
          end
        end
        DONE: begin
`ifdef ARB_RR_EN
          last_grant <= grant;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at request time and popped on each ready pulse.
module tb_mem_arbiter;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_strobe, I_rw, D_strobe, D_rw;
  logic [31:0] I_addr, I_wdata, D_addr, D_wdata;
  logic        I_ready, D_ready, S_strobe, S_rw, grant;
  logic [31:0] I_rdata, D_rdata, S_addr, S_wdata, S_rdata;

  typedef struct {
    bit          port;
    bit          rw;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .I_strobe(I_strobe), .I_rw(I_rw), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_ready(I_ready), .I_rdata(I_rdata),
    .D_strobe(D_strobe), .D_rw(D_rw), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .S_strobe(S_strobe), .S_rw(S_rw), .S_addr(S_addr), .S_wdata(S_wdata),
    .S_rdata(S_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    I_strobe = 0; I_rw = 0; I_addr = '0; I_wdata = '0;
    D_strobe = 0; D_rw = 0; D_addr = '0; D_wdata = '0;
    S_rdata = '0;
    repeat (3) tick;
    chk_cnt++;
    if ({S_strobe, S_rw, I_ready, D_ready, grant} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {S_strobe, S_rw, I_ready, D_ready, grant});
    else pass_cnt++;
    chk_cnt++;
    if ({S_addr, S_wdata} !== 64'h0)
      $display("FAIL reset_bus: addr %h wdata %h want 0", S_addr, S_wdata);
    else pass_cnt++;
    chk_cnt++;
    if ({I_rdata, D_rdata} !== 64'h0)
      $display("FAIL reset_rdata: I %h D %h want 0", I_rdata, D_rdata);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // One transaction from one port, checked against the queued expectation.
  task automatic run_txn(input bit port, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdat, input string nm);
    exp_t e;
    int   lat;
    bit   done, bus_ok, other_ok;
    tick;
    S_rdata = rdat;
    if (port) begin D_strobe = 1; D_rw = rw; D_addr = addr; D_wdata = wdata; end
    else      begin I_strobe = 1; I_rw = rw; I_addr = addr; I_wdata = wdata; end
    exp_q.push_back('{port, rw, rdat});
    done = 0; bus_ok = 1; other_ok = 1; lat = 0;
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      tick;
      if (port ? I_ready : D_ready) other_ok = 0;
      if (S_strobe !== (cyc == 1)) bus_ok = 0;
      if (cyc <= 1 + WS && (S_rw !== rw || S_addr !== addr || S_wdata !== wdata)) bus_ok = 0;
      if (port ? D_ready : I_ready) begin
        done = 1; lat = cyc;
        I_strobe = 0; D_strobe = 0;
        e = exp_q.pop_front();
        chk_cnt++;
        if (grant !== e.port) $display("FAIL %s_grant: got %b want %b", nm, grant, e.port);
        else pass_cnt++;
        if (!e.rw) begin
          chk_cnt++;
          if ((e.port ? D_rdata : I_rdata) !== e.rdata)
            $display("FAIL %s_rdata: got %h want %h", nm, e.port ? D_rdata : I_rdata, e.rdata);
          else pass_cnt++;
        end
      end
    end
    chk_cnt++;
    if (lat != 2 + WS) $display("FAIL %s_latency: got %0d want %0d", nm, lat, 2 + WS);
    else pass_cnt++;
    chk_cnt++;
    if (!bus_ok) $display("FAIL %s_bus: strobe/rw/addr/wdata not as issued (got %b want 1)", nm, bus_ok);
    else pass_cnt++;
    chk_cnt++;
    if (!other_ok) $display("FAIL %s_other_ready: got 1 want 0", nm);
    else pass_cnt++;
    I_strobe = 0; D_strobe = 0;
  endtask

  task automatic test_single_read;
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, "i_read");
    run_txn(1'b1, 1'b0, 32'h2C0, 32'h0, 32'h0BADF00D, "d_read");
  endtask

  task automatic test_single_write;
    run_txn(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hFFFFFFFF, "d_write");
    chk_cnt++;
    if ({I_rdata, D_rdata} !== {32'hDEADBEEF, 32'h0BADF00D})
      $display("FAIL rdata_hold: I %h D %h want deadbeef 0badf00d", I_rdata, D_rdata);
    else pass_cnt++;
  endtask

  task automatic test_tie;
    exp_t e;
    int   n, last;
    bit   both;
    rst = 1'b1; tick; rst = 1'b0;
    tick;
    S_rdata = 32'hCAFE0000;
    I_strobe = 1; I_rw = 0; I_addr = 32'h200;
    D_strobe = 1; D_rw = 0; D_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_q.push_back('{bit'(k % 2), 1'b0, 32'hCAFE0000});
`else
      exp_q.push_back('{1'b1, 1'b0, 32'hCAFE0000});
`endif
    end
    n = 0; last = -1; both = 0;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      tick;
      if (I_ready && D_ready) both = 1;
      if (I_ready || D_ready) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (D_ready !== e.port) $display("FAIL tie_port%0d: got D_ready=%b want %b", n, D_ready, e.port);
        else pass_cnt++;
        chk_cnt++;
        if (cyc != (last < 0 ? 2 + WS : last + 3 + WS))
          $display("FAIL tie_spacing%0d: got cycle %0d want %0d", n, cyc, last < 0 ? 2 + WS : last + 3 + WS);
        else pass_cnt++;
        chk_cnt++;
        if ((D_ready ? D_rdata : I_rdata) !== e.rdata)
          $display("FAIL tie_rdata%0d: got %h want %h", n, D_ready ? D_rdata : I_rdata, e.rdata);
        else pass_cnt++;
        last = cyc; n++;
      end
    end
    I_strobe = 0; D_strobe = 0;
    chk_cnt++;
    if (n != 4) $display("FAIL tie_count: got %0d readies want 4", n);
    else pass_cnt++;
    chk_cnt++;
    if (both) $display("FAIL tie_both_ready: got 1 want 0");
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    bit seen;
    tick;
    S_rdata = 32'h55AA55AA;
    I_strobe = 1; I_rw = 0; I_addr = 32'h80; I_wdata = 32'h77;
    tick; tick;
    rst = 1'b1; I_strobe = 0;
    tick;
    chk_cnt++;
    if ({S_strobe, S_rw, I_ready, D_ready, grant, S_addr, S_wdata, I_rdata, D_rdata} !== '0)
      $display("FAIL midrst_zero: addr %h wdata %h Ird %h Drd %h grant %b", S_addr, S_wdata, I_rdata, D_rdata, grant);
    else pass_cnt++;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick;
      if (I_ready || D_ready || S_strobe) seen = 1;
    end
    chk_cnt++;
    if (seen) $display("FAIL midrst_no_ready: got activity want none");
    else pass_cnt++;
    run_txn(1'b0, 1'b0, 32'h84, 32'h0, 32'h13579BDF, "post_rst");
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_tie;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
